// File: rtl/hcsr04_ranging_ctrl.sv
// hcsr04_ranging_ctrl: periodic trigger/echo sequencer for an HC-SR04-class ultrasonic sensor.
// Times the echo pulse in microseconds, converts it to a 13-bit distance in mm and strobes
// each valid sample into the downstream averaging filter. Missing or over-long echoes raise
// timeout_err instead and leave data_bin untouched.
module hcsr04_ranging_ctrl #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned PERIOD_MS  = 60,
    parameter int unsigned RISE_TO_US = 1000,
    parameter int unsigned ECHO_TO_US = 25000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    input  logic        echo,
    output logic        trig,
    output logic [12:0] data_bin,
    output logic        sample_vld,
    output logic        timeout_err,
    output logic        busy
);

    localparam int unsigned TICK_DIV   = CLK_FREQ / 1_000_000;
    localparam int unsigned PERIOD_CYC = CLK_FREQ / 1000 * PERIOD_MS;
    localparam int unsigned TICK_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PER_W      = (PERIOD_CYC > 4194303) ? $clog2(PERIOD_CYC + 1) : 22;
    localparam int unsigned PH_MAX     = (TRIG_US > RISE_TO_US) ? TRIG_US : RISE_TO_US;
    localparam int unsigned PH_W       = $clog2(PH_MAX + 1);

    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [PH_W-1:0]   TRIG_LAST   = PH_W'(TRIG_US - 1);
    localparam logic [PH_W-1:0]   RISE_LAST   = PH_W'(RISE_TO_US - 1);
    localparam logic [14:0]       ECHO_LIM    = 15'(ECHO_TO_US);
    localparam logic [PER_W-1:0]  PERIOD_MAX  = PER_W'(PERIOD_CYC);
    localparam logic [PER_W-1:0]  PERIOD_LAST = PER_W'(PERIOD_CYC - 1);
    // 343 m/s round trip halved: 0.1715 mm/us scaled by 2^16.
    localparam logic [28:0]       MM_SCALE    = 29'd11239;

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitRise,
        StMeasure,
        StCalc,
        StHold
    } state_e;

    state_e state_q, state_d;

    logic              echo_meta_q, echo_s_q, echo_d_q;
    logic              echo_rise, echo_fall;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic [PH_W-1:0]   phase_cnt_q, phase_cnt_d;
    logic [14:0]       us_cnt_q, us_cnt_d;
    logic [PER_W-1:0]  period_cnt_q, period_cnt_d;
    logic              period_done;
    logic [12:0]       data_bin_q, data_bin_d;
    logic              sample_vld_q, sample_vld_d;
    logic              timeout_err_q, timeout_err_d;
    logic [28:0]       mm_prod;

    // Bring the asynchronous echo into sys_clk and keep one more copy for edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_d_q    <= 1'b0;
        end else begin
            echo_meta_q <= echo;
            echo_s_q    <= echo_meta_q;
            echo_d_q    <= echo_s_q;
        end
    end

    assign echo_rise   = echo_s_q & ~echo_d_q;
    assign echo_fall   = ~echo_s_q & echo_d_q;
    assign tick        = (tick_cnt_q == TICK_LAST);
    // Ending one cycle early makes trigger rises exactly PERIOD_CYC cycles apart.
    assign period_done = (period_cnt_q >= PERIOD_LAST);
    // The product of a 15-bit count fits in 29 bits and bits [28:16] never exceed 8191,
    // so the saturation to 8191 is implicit in the slice.
    assign mm_prod     = {14'd0, us_cnt_q} * MM_SCALE;

    // State, counters and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= StIdle;
            tick_cnt_q    <= '0;
            phase_cnt_q   <= '0;
            us_cnt_q      <= '0;
            period_cnt_q  <= '0;
            data_bin_q    <= '0;
            sample_vld_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            phase_cnt_q   <= phase_cnt_d;
            us_cnt_q      <= us_cnt_d;
            period_cnt_q  <= period_cnt_d;
            data_bin_q    <= data_bin_d;
            sample_vld_q  <= sample_vld_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Measurement sequencing: next state, counter updates and output strobes.
    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick ? '0 : tick_cnt_q + TICK_W'(1);
        phase_cnt_d   = phase_cnt_q;
        us_cnt_d      = us_cnt_q;
        period_cnt_d  = (period_cnt_q == PERIOD_MAX) ? period_cnt_q : period_cnt_q + PER_W'(1);
        data_bin_d    = data_bin_q;
        sample_vld_d  = 1'b0;
        timeout_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable && !echo_s_q) begin
                    state_d      = StTrig;
                    tick_cnt_d   = '0;
                    phase_cnt_d  = '0;
                    period_cnt_d = '0;
                end
            end
            StTrig: begin
                if (tick) begin
                    if (phase_cnt_q == TRIG_LAST) begin
                        state_d     = StWaitRise;
                        phase_cnt_d = '0;
                    end else begin
                        phase_cnt_d = phase_cnt_q + PH_W'(1);
                    end
                end
            end
            StWaitRise: begin
                // A rise in the same cycle as the last timeout tick still counts as an echo.
                if (echo_rise) begin
                    state_d    = StMeasure;
                    us_cnt_d   = '0;
                    tick_cnt_d = '0;
                end else if (tick) begin
                    if (phase_cnt_q == RISE_LAST) begin
                        state_d       = StHold;
                        timeout_err_d = 1'b1;
                    end else begin
                        phase_cnt_d = phase_cnt_q + PH_W'(1);
                    end
                end
            end
            StMeasure: begin
                if (us_cnt_q == ECHO_LIM) begin
                    state_d       = StHold;
                    timeout_err_d = 1'b1;
                end else begin
                    // Counting a tick in the fall cycle gives floor(high_cycles / TICK_DIV).
                    if (tick) begin
                        us_cnt_d = us_cnt_q + 15'd1;
                    end
                    if (echo_fall) begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                data_bin_d   = mm_prod[28:16];
                sample_vld_d = 1'b1;
                state_d      = StHold;
            end
            StHold: begin
                // A late echo still high at period end defers the next trigger.
                if (period_done && !echo_s_q) begin
                    if (enable) begin
                        state_d      = StTrig;
                        tick_cnt_d   = '0;
                        phase_cnt_d  = '0;
                        period_cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign trig        = (state_q == StTrig);
    assign busy        = (state_q != StIdle);
    assign data_bin    = data_bin_q;
    assign sample_vld  = sample_vld_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hcsr04_ranging_ctrl.sv
// Bench for hcsr04_ranging_ctrl with a scaled-down timebase (2 MHz clock, 2 ms period).
module tb_hcsr04_ranging_ctrl;

    localparam int CLK_FREQ   = 2_000_000;
    localparam int TRIG_US    = 10;
    localparam int PERIOD_MS  = 2;
    localparam int RISE_TO_US = 200;
    localparam int ECHO_TO_US = 1500;

    localparam int TICK_DIV   = CLK_FREQ / 1_000_000;
    localparam int PERIOD_CYC = CLK_FREQ / 1000 * PERIOD_MS;
    localparam int TRIG_CYC   = TRIG_US * TICK_DIV;
    localparam int RISE_CYC   = RISE_TO_US * TICK_DIV;
    localparam int ECHO_CYC   = ECHO_TO_US * TICK_DIV;
    localparam int HELD_CYC   = 5000;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        enable    = 1'b0;
    logic        echo      = 1'b0;
    logic        trig;
    logic [12:0] data_bin;
    logic        sample_vld;
    logic        timeout_err;
    logic        busy;

    hcsr04_ranging_ctrl #(
        .CLK_FREQ   (CLK_FREQ),
        .TRIG_US    (TRIG_US),
        .PERIOD_MS  (PERIOD_MS),
        .RISE_TO_US (RISE_TO_US),
        .ECHO_TO_US (ECHO_TO_US)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .enable      (enable),
        .echo        (echo),
        .trig        (trig),
        .data_bin    (data_bin),
        .sample_vld  (sample_vld),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Global event counts, sampled away from the active edge.
    int   n_vld = 0, n_to = 0, n_trig = 0, n_overlap = 0;
    logic trig_prev = 1'b0;
    always @(negedge sys_clk) begin
        if (sample_vld) n_vld++;
        if (timeout_err) n_to++;
        if (sample_vld && timeout_err) n_overlap++;
        if (trig && !trig_prev) n_trig++;
        trig_prev = trig;
    end

    initial begin
        repeat (95000) @(posedge sys_clk);
        $display("FAIL watchdog: actual cycle budget exhausted, required test end");
        $fatal(1, "cycle budget exhausted");
    end

    typedef struct {
        int delay_cyc;
        int high_cyc;
        int exp_mm;
    } vec_t;

    vec_t vecs[7];

    int exp_vld     = 0;
    int exp_to      = 0;
    int last_mm     = 0;
    int last_rise_t = 0;
    bit on_period   = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Distance the filter should see for an echo high for high_cyc clocks.
    function automatic int ref_mm(input int high_cyc);
        longint us;
        longint mm;
        us = high_cyc / TICK_DIV;
        mm = (us * 343 * 65536 / 2000 + 1) / 65536;
        mm = (us * 11239) / 65536;
        return (mm > 8191) ? 8191 : int'(mm);
    endfunction

    task automatic wait_trig(output int t, output bit found);
        found = 1'b0;
        t     = 0;
        for (int i = 0; i < 2 * PERIOD_CYC; i++) begin
            if (trig) begin
                found = 1'b1;
                t     = cyc;
                return;
            end
            tick();
        end
    endtask

    // One trigger/echo cycle; high_cyc == 0 means the sensor never answers.
    task automatic run_meas(input string tag, input int delay_cyc, input int high_cyc,
                            input int exp_mm, input int drop_en_at);
        int t_rise;
        bit found;
        int w;
        int lat;
        int vld0;
        wait_trig(t_rise, found);
        check({tag, "_trig_seen"}, int'(found), 1);
        if (!found) return;
        if (on_period) check({tag, "_period"}, t_rise - last_rise_t, PERIOD_CYC);
        last_rise_t = t_rise;
        on_period   = 1'b1;
        w = 0;
        while (trig && w < 4 * TRIG_CYC) begin
            w++;
            tick();
        end
        check({tag, "_trig_width"}, w, TRIG_CYC);
        vld0 = n_vld;
        if (high_cyc == 0) begin
            lat = 0;
            for (int k = 1; k <= RISE_CYC + 20; k++) begin
                tick();
                if (timeout_err) begin
                    lat = k;
                    break;
                end
            end
            check({tag, "_rise_to_lat"}, lat, RISE_CYC);
            exp_to++;
            tick();
            check({tag, "_data_kept"}, int'(data_bin), last_mm);
            check({tag, "_no_vld"}, n_vld - vld0, 0);
        end else begin
            repeat (delay_cyc) tick();
            echo = 1'b1;
            for (int i = 0; i < high_cyc; i++) begin
                tick();
                if (i == drop_en_at) enable = 1'b0;
            end
            echo = 1'b0;
            lat = 0;
            for (int k = 1; k <= 12; k++) begin
                tick();
                if (sample_vld) begin
                    lat = k;
                    break;
                end
            end
            check({tag, "_vld_lat"}, lat, 4);
            check({tag, "_mm"}, int'(data_bin), exp_mm);
            exp_vld++;
            last_mm = exp_mm;
            tick();
            check({tag, "_vld_single"}, int'(sample_vld), 0);
        end
    endtask

    initial begin
        int  t;
        bit  found;
        int  w;
        int  lat;
        int  held;
        int  vld0;
        int  to0;
        int  tr0;
        int  d;
        int  h;

        // delay after trig fall, echo high time (clocks), expected mm
        vecs[0] = '{50, 2000, 171};   // 1000 us
        vecs[1] = '{10, 1000, 85};    // 500 us
        vecs[2] = '{0, 0, 0};         // no echo
        vecs[3] = '{10, 2998, 257};   // 1499 us
        vecs[4] = '{30, 13, 1};       // 6.5 us floors to 6
        vecs[5] = '{30, 11, 0};       // 5.5 us floors to 5
        vecs[6] = '{20, 2401, 205};   // 1200.5 us floors to 1200

        // Reset state.
        repeat (3) tick();
        check("rst_trig", int'(trig), 0);
        check("rst_data", int'(data_bin), 0);
        check("rst_vld", int'(sample_vld), 0);
        check("rst_to", int'(timeout_err), 0);
        check("rst_busy", int'(busy), 0);
        sys_rst_n = 1'b1;
        repeat (10) tick();
        check("idle_busy", int'(busy), 0);
        check("idle_trig", int'(trig), 0);

        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            run_meas($sformatf("vec%0d", i), vecs[i].delay_cyc, vecs[i].high_cyc,
                     vecs[i].exp_mm, -1);
        end

        for (int r = 0; r < 4; r++) begin
            d = int'($urandom_range(300, 0));
            h = int'($urandom_range(2900, 2));
            run_meas($sformatf("rand%0d", r), d, h, ref_mm(h), -1);
        end

        // Echo stuck high past the period: echo timeout, then the trigger waits for echo low.
        wait_trig(t, found);
        check("held_trig_seen", int'(found), 1);
        check("held_period", t - last_rise_t, PERIOD_CYC);
        w = 0;
        while (trig && w < 4 * TRIG_CYC) begin
            w++;
            tick();
        end
        check("held_trig_width", w, TRIG_CYC);
        repeat (20) tick();
        echo = 1'b1;
        vld0 = n_vld;
        tr0  = n_trig;
        lat  = 0;
        for (int k = 1; k <= ECHO_CYC + 20; k++) begin
            tick();
            if (timeout_err) begin
                lat = k;
                break;
            end
        end
        // 2 sync + 1 detect to MEASURE, ECHO_CYC to hit the limit, 1 to register the pulse.
        check("echo_to_lat", lat, ECHO_CYC + 4);
        exp_to++;
        held = (lat > 0) ? lat : ECHO_CYC + 20;
        repeat (HELD_CYC - held) tick();
        check("defer_no_trig", n_trig - tr0, 0);
        check("echo_to_no_vld", n_vld - vld0, 0);
        check("echo_to_data_kept", int'(data_bin), last_mm);
        echo = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (trig) begin
                lat = k;
                break;
            end
        end
        check("defer_trig_lat", lat, 3);
        on_period = 1'b0;

        // Dropping enable mid-MEASURE still delivers this sample, then the block idles.
        run_meas("endrop", 20, 2400, 205, 1000);
        tr0 = n_trig;
        repeat (PERIOD_CYC + 500) tick();
        check("endrop_no_trig", n_trig - tr0, 0);
        check("endrop_busy", int'(busy), 0);
        check("endrop_trig", int'(trig), 0);

        // Reset in the middle of a measurement.
        enable = 1'b1;
        tick();
        wait_trig(t, found);
        check("rstm_trig_seen", int'(found), 1);
        while (trig && w < 8 * TRIG_CYC) begin
            w++;
            tick();
        end
        repeat (10) tick();
        echo = 1'b1;
        repeat (300) tick();
        check("rstm_busy_before", int'(busy), 1);
        vld0 = n_vld;
        to0  = n_to;
        sys_rst_n = 1'b0;
        #1;
        check("rstm_trig", int'(trig), 0);
        check("rstm_busy", int'(busy), 0);
        check("rstm_vld", int'(sample_vld), 0);
        check("rstm_to", int'(timeout_err), 0);
        check("rstm_data", int'(data_bin), 0);
        echo    = 1'b0;
        last_mm = 0;
        repeat (4) tick();
        check("rstm_busy_held", int'(busy), 0);
        sys_rst_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (trig) begin
                lat = k;
                break;
            end
        end
        check("rstm_restart_in_2", int'(lat >= 1 && lat <= 2), 1);
        check("rstm_no_vld", n_vld - vld0, 0);
        check("rstm_no_to", n_to - to0, 0);

        tick();
        check("total_vld", n_vld, exp_vld);
        check("total_to", n_to, exp_to);
        check("vld_to_overlap", n_overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
